// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the power sequencer.
//   seq_state_e : sequencer states. Each state is named after the step most
//                 recently performed on the granted domain. PD_SW and PU_CLK
//                 are kept as named encodings, but the final step of each
//                 sequence returns straight to IDLE, so neither is ever held.
//   SETTLE_W    : width of the switch-on settle counter.
//   idx_w()     : width of a domain index, never less than 1 bit.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PD_CLK     = 4'd1,
    PD_ISO     = 4'd2,
    PD_SAVE    = 4'd3,
    PD_SW      = 4'd4,
    PU_SW      = 4'd5,
    PU_SETTLE  = 4'd6,
    PU_RESTORE = 4'd7,
    PU_ISO     = 4'd8,
    PU_CLK     = 4'd9
  } seq_state_e;

  localparam int SETTLE_W = 8;

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwr_rr_arb.sv
// Round-robin domain selector.
//   req         : per-domain pending vector.
//   ptr         : index searched first (the domain after the last one granted).
//   grant_idx   : first pending index found at or after ptr, wrapping around.
//   grant_valid : at least one domain is pending.
module pwr_rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  always_comb begin
    int j;
    j           = 0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Power-domain sequencer: powers domains down (gate clock, isolate, save,
// open switch) and up (close switch, settle, restore, release isolation,
// ungate clock), one domain at a time, chosen round-robin.
// Ports:
//   clk, reset (sync, active-low)
//   power_down / pm_en / test_mode : per-domain off request, enable, global force-on
//   clk_enable, isolation_enable, state_retention_enable (pulse),
//   state_retention_restore (pulse), power_switch_enable, domain_on : per-domain controls
//   busy       : sequencer is not IDLE
//   active_dom : index of the domain being sequenced, 0 while idle
//   dbg_state  : current sequencer state
// Handshake: there is no valid/ready pair; a domain is "requesting" while its
// target differs from domain_on, and a grant is taken only from IDLE.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter  int NUM_DOMAINS   = 4,
  parameter  int SETTLE_CYCLES = 8,
  localparam int IW            = idx_w(NUM_DOMAINS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_DOMAINS-1:0] power_down,
  input  logic [NUM_DOMAINS-1:0] pm_en,
  input  logic                   test_mode,
  output logic [NUM_DOMAINS-1:0] clk_enable,
  output logic [NUM_DOMAINS-1:0] isolation_enable,
  output logic [NUM_DOMAINS-1:0] state_retention_enable,
  output logic [NUM_DOMAINS-1:0] state_retention_restore,
  output logic [NUM_DOMAINS-1:0] power_switch_enable,
  output logic [NUM_DOMAINS-1:0] domain_on,
  output logic                   busy,
  output logic [IW-1:0]          active_dom,
  output seq_state_e             dbg_state
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
    (SETTLE_CYCLES == 0) ? '0 : SETTLE_W'(SETTLE_CYCLES - 1);

  seq_state_e            state;
  logic [IW-1:0]         rr_ptr;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [NUM_DOMAINS-1:0] target_off;
  logic [NUM_DOMAINS-1:0] pending;
  logic [IW-1:0]         grant_idx;
  logic                  grant_valid;
  logic [IW-1:0]         next_ptr;

  assign target_off = power_down & pm_en & {NUM_DOMAINS{~test_mode}};
  // Pending when the target ("on" = ~target_off) disagrees with domain_on.
  assign pending    = ~target_off ^ domain_on;
  assign next_ptr   = (grant_idx == IW'(NUM_DOMAINS - 1)) ? '0 : grant_idx + 1'b1;
  assign dbg_state  = state;

  pwr_rr_arb #(.N(NUM_DOMAINS), .IW(IW)) u_arb (
    .req         (pending),
    .ptr         (rr_ptr),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= IDLE;
      rr_ptr                  <= '0;
      settle_cnt              <= '0;
      clk_enable              <= '1;
      isolation_enable        <= '0;
      state_retention_enable  <= '0;
      state_retention_restore <= '0;
      power_switch_enable     <= '1;
      domain_on               <= '1;
      busy                    <= 1'b0;
      active_dom              <= '0;
    end else begin
      // Retention strobes are single-cycle: cleared every edge unless set below.
      state_retention_enable  <= '0;
      state_retention_restore <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            active_dom <= grant_idx;
            rr_ptr     <= next_ptr;
            busy       <= 1'b1;
            if (domain_on[grant_idx]) begin
              clk_enable[grant_idx] <= 1'b0;
              state                 <= PD_CLK;
            end else begin
              power_switch_enable[grant_idx] <= 1'b1;
              state                          <= PU_SW;
            end
          end
        end
        PD_CLK: begin
          isolation_enable[active_dom] <= 1'b1;
          state                        <= PD_ISO;
        end
        PD_ISO: begin
          state_retention_enable[active_dom] <= 1'b1;
          state                              <= PD_SAVE;
        end
        PD_SAVE: begin
          power_switch_enable[active_dom] <= 1'b0;
          domain_on[active_dom]           <= 1'b0;
          busy                            <= 1'b0;
          active_dom                      <= '0;
          state                           <= IDLE;
        end
        PU_SW: begin
          if (SETTLE_CYCLES == 0) begin
            state_retention_restore[active_dom] <= 1'b1;
            state                               <= PU_RESTORE;
          end else begin
            settle_cnt <= SETTLE_LOAD;
            state      <= PU_SETTLE;
          end
        end
        PU_SETTLE: begin
          // Counts down from SETTLE_CYCLES-1; the edge that sees zero ends settling.
          if (settle_cnt == '0) begin
            state_retention_restore[active_dom] <= 1'b1;
            state                               <= PU_RESTORE;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        PU_RESTORE: begin
          isolation_enable[active_dom] <= 1'b0;
          state                        <= PU_ISO;
        end
        PU_ISO: begin
          clk_enable[active_dom] <= 1'b1;
          domain_on[active_dom]  <= 1'b1;
          busy                   <= 1'b0;
          active_dom             <= '0;
          state                  <= IDLE;
        end
        default: begin
          busy       <= 1'b0;
          active_dom <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
